// File: rtl/com_pkg.sv
// Shared types and default widths for the multi-channel centroid engine.
package com_pkg;

  // Engine phases: pixel accumulation, then a per-channel divide/emit walk,
  // then a one-cycle wipe of the accumulators before the next frame.
  typedef enum logic [2:0] {
    ACCUM = 3'd0,
    LOAD  = 3'd1,
    DIV_X = 3'd2,
    DIV_Y = 3'd3,
    EMIT  = 3'd4,
    CLEAR = 3'd5
  } com_state_t;

  localparam int NUM_CH_DEF    = 4;
  localparam int H_W_DEF       = 11;
  localparam int V_W_DEF       = 10;
  localparam int CNT_W_DEF     = 20;
  localparam int MIN_COUNT_DEF = 16;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle.
// start_in is sampled on a clock edge; done_out is a one-cycle pulse that
// rises WIDTH+1 cycles after the cycle in which start_in was high. A new
// start_in may be given in the same cycle as done_out.
// Dividing by zero yields an all-ones quotient and remainder = dividend.
module seq_divider #(
  parameter int WIDTH = 31
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             done_out,
  output logic             busy_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};
  end

  // One restoring step per cycle; the quotient register doubles as the
  // dividend shift register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_in) begin
        rem_q  <= '0;
        quo_q  <= dividend_in;
        div_q  <= divisor_in;
        cnt_q  <= CW'(WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (trial[WIDTH]) begin
          rem_q <= shifted;
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_q <= trial;
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient_out  = quo_q;
  assign remainder_out = rem_q[WIDTH-1:0];
  assign done_out      = done_q;
  assign busy_out      = busy_q;

endmodule

// File: rtl/multi_center_of_mass.sv
// Per-frame centroid engine for NUM_CH pixel classes sharing one pixel stream.
// Pixels are accumulated per channel; on tabulate each channel is divided in
// turn through one shared sequential divider and reported as one result beat.
//
// Stream semantics: there is no back-pressure. valid_in qualifies x_in, y_in
// and mask_in for exactly one cycle and is only honoured while busy_out=0;
// pixels and tabulate_in offered while busy_out=1 are silently dropped.
// valid_out is a one-cycle strobe qualifying the registered result fields,
// which hold their value until the next beat.
module multi_center_of_mass
  import com_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int H_W       = H_W_DEF,
  parameter int V_W       = V_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MIN_COUNT = MIN_COUNT_DEF,
  localparam int XS_W     = H_W + CNT_W,
  localparam int YS_W     = V_W + CNT_W,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [H_W-1:0]    x_in,
  input  logic [V_W-1:0]    y_in,
  input  logic [NUM_CH-1:0] mask_in,
  input  logic              valid_in,
  input  logic              tabulate_in,
  output logic              busy_out,
  output logic [H_W-1:0]    x_out,
  output logic [V_W-1:0]    y_out,
  output logic [CH_W-1:0]   ch_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              found_out,
  output logic              sat_out,
  output logic              valid_out,
  output logic              done_out,
  output logic [2:0]        state_dbg_out
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W:0]  MIN_CNT = (CNT_W + 1)'(MIN_COUNT);

  // Per-channel accumulators and their next-state values.
  logic [XS_W-1:0]   xs_q  [NUM_CH];
  logic [YS_W-1:0]   ys_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] sat_q;
  logic [XS_W-1:0]   xs_d  [NUM_CH];
  logic [YS_W-1:0]   ys_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sat_d;

  // Sequencer state and registered outputs.
  com_state_t        state_q;
  logic [CH_W-1:0]   ch_idx_q;
  logic [H_W-1:0]    qx_q;
  logic              busy_q;
  logic [H_W-1:0]    x_q;
  logic [V_W-1:0]    y_q;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  count_q;
  logic              found_q;
  logic              sat_out_q;
  logic              valid_q;
  logic              done_q;

  // Shared divider interface.
  logic              div_start;
  logic [XS_W-1:0]   div_dividend;
  logic [XS_W-1:0]   div_divisor;
  logic [XS_W-1:0]   div_quo;
  logic [XS_W-1:0]   div_rem;
  logic              div_done;
  logic              div_busy;

  // Facts about the channel currently being reported.
  logic [CNT_W-1:0]  cur_cnt;
  logic              cur_sat;
  logic              cur_found;
  logic              cur_last;

  assign cur_cnt   = cnt_q[ch_idx_q];
  assign cur_sat   = sat_q[ch_idx_q];
  assign cur_found = ({1'b0, cur_cnt} >= MIN_CNT);
  assign cur_last  = (ch_idx_q == LAST_CH);

  // Divider is kicked from LOAD for the x sum and again on x completion for
  // the y sum; the count divisor is stable throughout a channel's walk.
  always_comb begin
    div_start    = ((state_q == LOAD) && (cur_cnt != '0)) ||
                   ((state_q == DIV_X) && div_done);
    div_dividend = (state_q == LOAD) ? xs_q[ch_idx_q] : XS_W'(ys_q[ch_idx_q]);
    div_divisor  = XS_W'(cur_cnt);
  end

  seq_divider #(
    .WIDTH (XS_W)
  ) u_div (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (div_start),
    .dividend_in   (div_dividend),
    .divisor_in    (div_divisor),
    .quotient_out  (div_quo),
    .remainder_out (div_rem),
    .done_out      (div_done),
    .busy_out      (div_busy)
  );

  // Sanity of the divider hand-off: a finished divide leaves a remainder
  // below the count, and a new divide is never started over a running one.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (div_done) assert (div_rem < div_divisor);
      assert (!(div_start && div_busy));
    end
  end

  // Accumulate accepted pixels per channel; a full counter drops the pixel
  // for that channel and flags saturation instead of wrapping.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      xs_d[c]  = xs_q[c];
      ys_d[c]  = ys_q[c];
      cnt_d[c] = cnt_q[c];
    end
    sat_d = sat_q;
    if (state_q == CLEAR) begin
      for (int c = 0; c < NUM_CH; c++) begin
        xs_d[c]  = '0;
        ys_d[c]  = '0;
        cnt_d[c] = '0;
      end
      sat_d = '0;
    end else if ((state_q == ACCUM) && valid_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask_in[c]) begin
          if (&cnt_q[c]) begin
            sat_d[c] = 1'b1;
          end else begin
            xs_d[c]  = xs_q[c] + XS_W'(x_in);
            ys_d[c]  = ys_q[c] + YS_W'(y_in);
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        xs_q[c]  <= '0;
        ys_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      sat_q <= '0;
    end else begin
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // Frame sequencer: walks every channel through LOAD/DIV_X/DIV_Y/EMIT and
  // publishes each result on the edge that enters EMIT.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ACCUM;
      ch_idx_q  <= '0;
      qx_q      <= '0;
      busy_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      ch_q      <= '0;
      count_q   <= '0;
      found_q   <= 1'b0;
      sat_out_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (tabulate_in) begin
            state_q  <= LOAD;
            ch_idx_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        LOAD: begin
          if (cur_cnt == '0) begin
            // Empty channel: report zeros without touching the divider.
            x_q       <= '0;
            y_q       <= '0;
            ch_q      <= ch_idx_q;
            count_q   <= cur_cnt;
            found_q   <= cur_found;
            sat_out_q <= cur_sat;
            valid_q   <= 1'b1;
            done_q    <= cur_last;
            state_q   <= EMIT;
          end else begin
            state_q <= DIV_X;
          end
        end
        DIV_X: begin
          if (div_done) begin
            // The mean never exceeds the largest coordinate, so the upper
            // quotient bits are always zero.
            qx_q    <= div_quo[H_W-1:0];
            state_q <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) begin
            x_q       <= qx_q;
            y_q       <= div_quo[V_W-1:0];
            ch_q      <= ch_idx_q;
            count_q   <= cur_cnt;
            found_q   <= cur_found;
            sat_out_q <= cur_sat;
            valid_q   <= 1'b1;
            done_q    <= cur_last;
            state_q   <= EMIT;
          end
        end
        EMIT: begin
          if (cur_last) begin
            state_q <= CLEAR;
          end else begin
            ch_idx_q <= ch_idx_q + CH_W'(1);
            state_q  <= LOAD;
          end
        end
        CLEAR: begin
          state_q <= ACCUM;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ACCUM;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out      = busy_q;
  assign x_out         = x_q;
  assign y_out         = y_q;
  assign ch_out        = ch_q;
  assign count_out     = count_q;
  assign found_out     = found_q;
  assign sat_out       = sat_out_q;
  assign valid_out     = valid_q;
  assign done_out      = done_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_multi_center_of_mass.sv
// Testbench for multi_center_of_mass: directed frames plus randomized frames,
// each result beat compared against an arithmetic centroid model.
module tb_multi_center_of_mass;

  localparam int NUM_CH    = 4;
  localparam int H_W       = 11;
  localparam int V_W       = 10;
  localparam int CNT_W     = 5;
  localparam int MIN_COUNT = 3;
  localparam int XS_W      = H_W + CNT_W;
  localparam int CH_W      = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int DIV_CYC   = XS_W + 1;

  // ---------------- clock / reset ----------------
  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [H_W-1:0]    x_in;
  logic [V_W-1:0]    y_in;
  logic [NUM_CH-1:0] mask_in;
  logic              valid_in;
  logic              tabulate_in;
  logic              busy_out;
  logic [H_W-1:0]    x_out;
  logic [V_W-1:0]    y_out;
  logic [CH_W-1:0]   ch_out;
  logic [CNT_W-1:0]  count_out;
  logic              found_out;
  logic              sat_out;
  logic              valid_out;
  logic              done_out;
  logic [2:0]        state_dbg;

  always #5 clk_in = ~clk_in;

  multi_center_of_mass #(
    .NUM_CH    (NUM_CH),
    .H_W       (H_W),
    .V_W       (V_W),
    .CNT_W     (CNT_W),
    .MIN_COUNT (MIN_COUNT)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .mask_in       (mask_in),
    .valid_in      (valid_in),
    .tabulate_in   (tabulate_in),
    .busy_out      (busy_out),
    .x_out         (x_out),
    .y_out         (y_out),
    .ch_out        (ch_out),
    .count_out     (count_out),
    .found_out     (found_out),
    .sat_out       (sat_out),
    .valid_out     (valid_out),
    .done_out      (done_out),
    .state_dbg_out (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          px_x[$];
  int          px_y[$];
  logic [NUM_CH-1:0] px_m[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_beat(input int x, input int y, input int c,
                                            input int n, input bit f, input bit s);
    return {2'b00, s, f, CNT_W'(n), CH_W'(c), V_W'(y), H_W'(x)};
  endfunction

  // Reference: per channel, the first CNT_MAX member pixels are counted,
  // centroid = floor(mean), later members only raise the saturation flag.
  task automatic build_expected();
    int n, tot, acc_cyc, ex, ey;
    longint sx, sy;
    acc_cyc = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      n = 0; tot = 0; sx = 0; sy = 0;
      for (int i = 0; i < px_x.size(); i++) begin
        if (px_m[i][c]) begin
          tot++;
          if (tot <= CNT_MAX) begin
            n++;
            sx += px_x[i];
            sy += px_y[i];
          end
        end
      end
      ex = (n == 0) ? 0 : int'(sx / n);
      ey = (n == 0) ? 0 : int'(sy / n);
      acc_cyc += (n == 0) ? 2 : (2 + 2 * DIV_CYC);
      exp_q.push_back(pack_beat(ex, ey, c, n, n >= MIN_COUNT, tot > CNT_MAX));
      exp_cyc_q.push_back(acc_cyc);
    end
    px_x.delete(); px_y.delete(); px_m.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    valid_in = 1'b0; tabulate_in = 1'b0;
    x_in = '0; y_in = '0; mask_in = '0;
  endtask

  task automatic drive_junk();
    valid_in    = 1'($urandom_range(0, 1));
    tabulate_in = ($urandom_range(0, 3) == 0);
    x_in        = H_W'($urandom_range(0, (1 << H_W) - 1));
    y_in        = V_W'($urandom_range(0, (1 << V_W) - 1));
    mask_in     = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
  endtask

  task automatic idle_cycle();
    drive_junk();
    valid_in = 1'b0; tabulate_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic send_pixel(input int x, input int y, input logic [NUM_CH-1:0] m);
    x_in = H_W'(x); y_in = V_W'(y); mask_in = m;
    valid_in = 1'b1; tabulate_in = 1'b0;
    px_x.push_back(x); px_y.push_back(y); px_m.push_back(m);
    @(posedge clk_in); #1;
    drive_idle();
  endtask

  task automatic tabulate(input bit with_px, input int x, input int y, input logic [NUM_CH-1:0] m);
    drive_idle();
    if (with_px) begin
      x_in = H_W'(x); y_in = V_W'(y); mask_in = m; valid_in = 1'b1;
      px_x.push_back(x); px_y.push_back(y); px_m.push_back(m);
    end
    tabulate_in = 1'b1;
    build_expected();
    @(posedge clk_in); #1;
    drive_idle();
  endtask

  // Walk one tabulation: junk on the inputs throughout, beats checked
  // against the model, beat timing checked against the latency formula.
  task automatic collect_frame();
    int cyc, beats, ec;
    bit done_seen;
    logic [31:0] e;
    cyc = 1; beats = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      drive_junk();
      @(negedge clk_in);
      check_eq("busy_during_walk", busy_out, 1);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_count", beats + 1, NUM_CH);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_eq("x_out",     x_out,     e[H_W-1:0]);
          check_eq("y_out",     y_out,     e[H_W+V_W-1:H_W]);
          check_eq("ch_out",    ch_out,    e[H_W+V_W+CH_W-1:H_W+V_W]);
          check_eq("count_out", count_out, e[H_W+V_W+CH_W+CNT_W-1:H_W+V_W+CH_W]);
          check_eq("found_out", found_out, e[H_W+V_W+CH_W+CNT_W]);
          check_eq("sat_out",   sat_out,   e[H_W+V_W+CH_W+CNT_W+1]);
          check_eq("beat_cycle", cyc, ec);
          check_eq("done_flag", done_out, (beats == NUM_CH - 1));
        end
        beats++;
        if (done_out) done_seen = 1'b1;
      end else begin
        check_eq("done_without_valid", done_out, 0);
      end
      @(posedge clk_in); #1;
      cyc++;
    end
    check_eq("done_seen", done_seen, 1);
    check_eq("beats_per_frame", beats, NUM_CH);
    drive_junk();
    @(negedge clk_in);
    check_eq("busy_in_clear", busy_out, 1);
    check_eq("valid_in_clear", valid_out, 0);
    drive_idle();
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check_eq("busy_after_clear", busy_out, 0);
    @(posedge clk_in); #1;
    exp_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_busy"},  busy_out,  0);
    check_eq({pfx, "_valid"}, valid_out, 0);
    check_eq({pfx, "_done"},  done_out,  0);
    check_eq({pfx, "_x"},     x_out,     0);
    check_eq({pfx, "_y"},     y_out,     0);
    check_eq({pfx, "_ch"},    ch_out,    0);
    check_eq({pfx, "_count"}, count_out, 0);
    check_eq({pfx, "_found"}, found_out, 0);
    check_eq({pfx, "_sat"},   sat_out,   0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] m;
    rst_in = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk_in);
    check_outputs_zero("reset");
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Channel 0 only, count exactly at the found threshold.
    send_pixel(10, 20, 4'b0001);
    send_pixel(20, 40, 4'b0001);
    send_pixel(30, 60, 4'b0001);
    tabulate(1'b0, 0, 0, '0);
    collect_frame();

    // Two channels sharing pixels, count below threshold, fractional mean.
    send_pixel(100, 50, 4'b0011);
    send_pixel(101, 51, 4'b0011);
    tabulate(1'b0, 0, 0, '0);
    collect_frame();

    // Pixel in the tabulate cycle is included; junk during the walk is not.
    tabulate(1'b1, 7, 9, 4'b0001);
    collect_frame();

    // Saturation: ch0 overflows, ch1 lands exactly on the maximum count.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      m = (i < CNT_MAX) ? 4'b0011 : 4'b0001;
      send_pixel($urandom_range(0, (1 << H_W) - 1), $urandom_range(0, (1 << V_W) - 1), m);
    end
    tabulate(1'b0, 0, 0, '0);
    collect_frame();

    // Saturation flag does not survive into the next frame.
    send_pixel(1000, 500, 4'b1001);
    tabulate(1'b0, 0, 0, '0);
    collect_frame();

    // Empty frame.
    tabulate(1'b0, 0, 0, '0);
    collect_frame();

    // Asynchronous reset while channel 0 is in its x divide.
    send_pixel(300, 200, 4'b1111);
    send_pixel(301, 201, 4'b1111);
    tabulate(1'b0, 0, 0, '0);
    exp_q.delete(); exp_cyc_q.delete();
    repeat (6) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    send_pixel(5, 5, 4'b0001);
    tabulate(1'b0, 0, 0, '0);
    collect_frame();

    // Randomized back-to-back frames.
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        m = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
        if (f % 4 == 0) m[0] = 1'b1;
        send_pixel($urandom_range(0, (1 << H_W) - 1), $urandom_range(0, (1 << V_W) - 1), m);
      end
      if ($urandom_range(0, 1) == 1)
        tabulate(1'b1, $urandom_range(0, (1 << H_W) - 1), $urandom_range(0, (1 << V_W) - 1),
                 NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)));
      else
        tabulate(1'b0, 0, 0, '0);
      collect_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
